// File: rtl/sad_pkg.sv
`timescale 1ns/1ps
// Shared constants for the SAD accumulator slice: FSM state codes, default widths, clog2 helper.
package sad_pkg;

    localparam int SUM_W_DEF = 12;
    localparam int BEAT_W_DEF = SUM_W_DEF + 2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ACCUM = 3'd1;
    localparam logic [2:0] ST_FLUSH = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/sad_cpa.sv
`timescale 1ns/1ps
// sad_cpa: registered carry-propagate adder resolving one redundant (sum, carry) beat.
module sad_cpa #(
    parameter int SUM_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SUM_W-1:0] in_sum,
    input  logic [SUM_W-1:0] in_carry,
    output logic [SUM_W+1:0] cpa_p1,
    output logic             vld_p1
);

    // stage 1: carry vector carries weight 2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpa_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= load;
            if (load)
                cpa_p1 <= {2'b00, in_sum} + {1'b0, in_carry, 1'b0};
        end
    end

endmodule

// File: rtl/sad_accumulator.sv
`timescale 1ns/1ps
// sad_accumulator: resolves compressor-tree beats and accumulates BLK_LEN of them into one SAD result.
// Define SAD_SAT_EN to saturate the accumulator (and report sad_ovf) instead of wrapping.
module sad_accumulator
    import sad_pkg::*;
#(
    parameter int SUM_W   = SUM_W_DEF,
    parameter int BLK_LEN = 16,
    parameter int ACC_W   = 17
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SUM_W-1:0]        in_sum,
    input  logic [SUM_W-1:0]        in_carry,
    output logic                    sad_valid,
    input  logic                    sad_ready,
    output logic [ACC_W-1:0]        sad_out,
    output logic                    sad_ovf,
    output logic [clog2(BLK_LEN):0] beat_cnt
);

    localparam int CNT_W = clog2(BLK_LEN) + 1;
    localparam int CPA_W = SUM_W + 2;
    localparam int EXT_W = ((ACC_W > CPA_W) ? ACC_W : CPA_W) + 1;
    localparam logic [EXT_W-1:0] ACC_MAX = {{(EXT_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLK_LEN - 1);

    logic [2:0]       state_p0, state_nx;
    logic [CPA_W-1:0] cpa_p1;
    logic             vld_p1;
    logic [ACC_W-1:0] acc_p2;
    logic             accept, last_beat, hs;

    assign in_ready  = ~rst & ((state_p0 == ST_IDLE) | (state_p0 == ST_ACCUM));
    assign accept    = in_valid & in_ready;
    assign last_beat = accept & (beat_cnt == LAST_CNT);
    assign hs        = sad_valid & sad_ready;

    function automatic logic [EXT_W-1:0] ext_add(input logic [ACC_W-1:0] a, input logic [CPA_W-1:0] b);
        return EXT_W'(a) + EXT_W'(b);
    endfunction

    function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a, input logic [CPA_W-1:0] b);
        logic [EXT_W-1:0] s;
        s = ext_add(a, b);
`ifdef SAD_SAT_EN
        if (s > ACC_MAX) return {ACC_W{1'b1}};
`endif
        return s[ACC_W-1:0];
    endfunction

    sad_cpa #(.SUM_W(SUM_W)) u_cpa (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .in_sum   (in_sum),
        .in_carry (in_carry),
        .cpa_p1   (cpa_p1),
        .vld_p1   (vld_p1)
    );

    always_comb begin
        state_nx = state_p0;
        case (state_p0)
            ST_IDLE:  if (accept) state_nx = last_beat ? ST_FLUSH : ST_ACCUM;
            ST_ACCUM: if (last_beat) state_nx = ST_FLUSH;
            ST_FLUSH: state_nx = ST_DRAIN;
            ST_DRAIN: state_nx = ST_HOLD;
            ST_HOLD:  if (hs) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p0 <= ST_IDLE;
            beat_cnt <= '0;
        end else begin
            state_p0 <= state_nx;
            if (hs)
                beat_cnt <= '0;
            else if (accept)
                beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // stage 2: accumulate resolved beats; the result handshake starts the next block from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc_p2 <= '0;
        else if (hs)
            acc_p2 <= '0;
        else if (vld_p1)
            acc_p2 <= acc_add(acc_p2, cpa_p1);
    end

`ifdef SAD_SAT_EN
    logic ovf_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_p2 <= 1'b0;
        else if (hs)
            ovf_p2 <= 1'b0;
        else if (vld_p1 && (ext_add(acc_p2, cpa_p1) > ACC_MAX))
            ovf_p2 <= 1'b1;
    end

    assign sad_ovf = ovf_p2;
`else
    assign sad_ovf = 1'b0;
`endif

    // stage 3: result register, loaded once the last add has landed in HOLD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sad_valid <= 1'b0;
            sad_out   <= '0;
        end else if (hs) begin
            sad_valid <= 1'b0;
        end else if (state_p0 == ST_HOLD && !sad_valid) begin
            sad_valid <= 1'b1;
            sad_out   <= acc_p2;
        end
    end

endmodule

// File: tb/tb_sad_accumulator.sv
`timescale 1ns/1ps
// Bench for sad_accumulator: directed block sequences with random beats against a running-sum model.
module tb_sad_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, sad_valid, sad_ready, sad_ovf;
    logic [11:0] in_sum, in_carry;
    logic [16:0] sad_out;
    logic [4:0]  beat_cnt;

    logic        s_in_valid, s_in_ready, s_sad_valid, s_sad_ready, s_sad_ovf;
    logic [11:0] s_in_sum, s_in_carry;
    logic [11:0] s_sad_out;
    logic [4:0]  s_beat_cnt;

    int     n_pass = 0;
    int     n_total = 0;
    longint exp_total;
    logic [16:0] held;

    always #5 clk = ~clk;

    sad_accumulator u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_carry(in_carry), .sad_valid(sad_valid),
        .sad_ready(sad_ready), .sad_out(sad_out), .sad_ovf(sad_ovf), .beat_cnt(beat_cnt)
    );

    sad_accumulator #(.SUM_W(12), .BLK_LEN(16), .ACC_W(12)) u_sat (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_sum(s_in_sum), .in_carry(s_in_carry), .sad_valid(s_sad_valid),
        .sad_ready(s_sad_ready), .sad_out(s_sad_out), .sad_ovf(s_sad_ovf), .beat_cnt(s_beat_cnt)
    );

    // Expected block result: positive beats only, so per-beat saturation equals clamping the total.
    function automatic logic [63:0] ref_sad(input longint total, input int accw);
        longint m;
        m = longint'(1) << accw;
`ifdef SAD_SAT_EN
        return (total > m - 1) ? 64'(m - 1) : 64'(total);
`else
        return 64'(total % m);
`endif
    endfunction

    function automatic logic [63:0] ref_ovf(input longint total, input int accw);
`ifdef SAD_SAT_EN
        return (total > (longint'(1) << accw) - 1) ? 64'd1 : 64'd0;
`else
        return (total < 0) ? 64'd1 : 64'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input int n, input int gap, input bit rnd, input string tag);
        logic [11:0] s, c;
        exp_total = 0;
        for (int i = 0; i < n; i++) begin
            s = rnd ? 12'($urandom) : 12'd3;
            c = rnd ? 12'($urandom) : 12'd1;
            in_valid = 1'b1;
            in_sum   = s;
            in_carry = c;
            chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
            tick;
            exp_total += longint'(s) + 2 * longint'(c);
            chk({tag, "_beat_cnt"}, 64'(beat_cnt), 64'(i + 1));
            in_valid = 1'b0;
            if (i < n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    tick;
                    chk({tag, "_cnt_stall"}, 64'(beat_cnt), 64'(i + 1));
                end
            end
        end
    endtask

    task automatic finish_block(input string tag);
        tick;
        chk({tag, "_vld_t1"}, 64'(sad_valid), 64'd0);
        tick;
        chk({tag, "_vld_t2"}, 64'(sad_valid), 64'd0);
        tick;
        chk({tag, "_vld_t3"}, 64'(sad_valid), 64'd1);
        chk({tag, "_sad_out"}, 64'(sad_out), ref_sad(exp_total, 17));
        chk({tag, "_sad_ovf"}, 64'(sad_ovf), ref_ovf(exp_total, 17));
        chk({tag, "_rdy_hold"}, 64'(in_ready), 64'd0);
    endtask

    task automatic handshake(input string tag);
        sad_ready = 1'b1;
        tick;
        sad_ready = 1'b0;
        chk({tag, "_hs_vld"}, 64'(sad_valid), 64'd0);
        chk({tag, "_hs_cnt"}, 64'(beat_cnt), 64'd0);
        chk({tag, "_hs_ovf"}, 64'(sad_ovf), 64'd0);
        chk({tag, "_hs_rdy"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint s_total;
        rst = 1'b1;
        in_valid = 1'b0; in_sum = '0; in_carry = '0; sad_ready = 1'b0;
        s_in_valid = 1'b0; s_in_sum = '0; s_in_carry = '0; s_sad_ready = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_sad_valid", 64'(sad_valid), 64'd0);
        chk("rst_sad_out", 64'(sad_out), 64'd0);
        chk("rst_sad_ovf", 64'(sad_ovf), 64'd0);
        chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        tick;
        tick;
        rst = 1'b0;
        tick;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // back-to-back block of constant beats: 16 * (3 + 2) = 80
        send_block(16, 0, 1'b0, "t1");
        finish_block("t1");
        chk("t1_value80", 64'(sad_out), 64'd80);
        handshake("t1");

        // in_valid every other cycle; the count stalls across gaps
        send_block(16, 1, 1'b0, "t2");
        finish_block("t2");
        handshake("t2");

        // random beats, then a long stall on sad_ready with extra in_valid that must be ignored
        send_block(16, 0, 1'b1, "t3");
        finish_block("t3");
        held = sad_out;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_sum   = 12'($urandom);
            in_carry = 12'($urandom);
            tick;
            chk("t3_stable", 64'(sad_out), 64'(held));
            chk("t3_in_ready", 64'(in_ready), 64'd0);
            chk("t3_valid", 64'(sad_valid), 64'd1);
            chk("t3_cnt", 64'(beat_cnt), 64'd16);
        end
        in_valid = 1'b0;
        handshake("t3");

        // reset after beat 7 discards the partial block
        send_block(7, 0, 1'b1, "t4p");
        rst = 1'b1;
        #1;
        chk("t4_rst_rdy", 64'(in_ready), 64'd0);
        chk("t4_rst_cnt", 64'(beat_cnt), 64'd0);
        chk("t4_rst_out", 64'(sad_out), 64'd0);
        tick;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("t4_no_valid", 64'(sad_valid), 64'd0);
        end
        send_block(16, 0, 1'b1, "t4");
        finish_block("t4");

        // handshake then a new block on the very next cycle
        handshake("t6a");
        send_block(16, 0, 1'b1, "t6");
        finish_block("t6");
        handshake("t6");

        // ACC_W=12 instance fed all-ones beats
        s_total = 0;
        for (int i = 0; i < 16; i++) begin
            s_in_valid = 1'b1;
            s_in_sum   = 12'hfff;
            s_in_carry = 12'hfff;
            tick;
            s_total += 4095 + 2 * 4095;
        end
        s_in_valid = 1'b0;
        tick;
        tick;
        tick;
        chk("t5_valid", 64'(s_sad_valid), 64'd1);
        chk("t5_sad_out", 64'(s_sad_out), ref_sad(s_total, 12));
        chk("t5_sad_ovf", 64'(s_sad_ovf), ref_ovf(s_total, 12));
        s_sad_ready = 1'b1;
        tick;
        s_sad_ready = 1'b0;
        chk("t5_hs_vld", 64'(s_sad_valid), 64'd0);
        chk("t5_hs_ovf", 64'(s_sad_ovf), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
